// File: rtl/sapra_irq_pkg.sv
// rtl/sapra_irq_pkg.sv - shared types, default vectors and priority encoder for sapra_irq_ctrl
package sapra_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'd8;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sapra_irq_edge.sv
// rtl/sapra_irq_edge.sv - rising-edge detector per IRQ line, optional 2-flop sync (SAPRA_IRQ_SYNC_EN)
module sapra_irq_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] irq_in,
  output logic [W-1:0] rise
);

  logic [W-1:0] in_s;
  logic [W-1:0] prev;

`ifdef SAPRA_IRQ_SYNC_EN
  logic [W-1:0] sync1;
  logic [W-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign in_s = sync2;
`else
  assign in_s = irq_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= in_s;
  end

  assign rise = in_s & ~prev;

endmodule

// File: rtl/sapra_irq_ctrl.sv
// rtl/sapra_irq_ctrl.sv - edge-latched, fixed-priority interrupt controller for the sapra core
// Optional input synchronizer enabled by defining SAPRA_IRQ_SYNC_EN.
module sapra_irq_ctrl
  import sapra_irq_pkg::*;
#(
  parameter int          N_IRQ      = 3,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                                        CLOCK_50,
  input  logic                                        KEY,
  input  logic [N_IRQ-1:0]                            irq_in,
  input  logic [N_IRQ-1:0]                            irq_en,
  input  logic                                        stall,
  input  logic                                        irq_ack,
  input  logic                                        irq_ret,
  output logic                                        irq_req,
  output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] irq_num,
  output logic [31:0]                                 vector,
  output logic                                        irq_active,
  output logic [N_IRQ-1:0]                            pending
);

  localparam int NW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t     state;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] clr;
  logic [7:0]     cand8;
  logic [2:0]     win;
  logic           take_ack;

  sapra_irq_edge #(.W(N_IRQ)) u_edge (
    .clk    (CLOCK_50),
    .rst_n  (KEY),
    .irq_in (irq_in),
    .rise   (rise)
  );

  assign cand     = pending & irq_en;
  assign take_ack = (state == REQ) && irq_ack;

  always_comb begin
    cand8 = '0;
    cand8[N_IRQ-1:0] = cand;
    win = prio_enc(cand8);
    clr = '0;
    if (take_ack) clr[irq_num] = 1'b1;
  end

  // A fresh edge on the line being acknowledged must survive the clear.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) pending <= '0;
    else      pending <= (pending & ~clr) | rise;
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state   <= IDLE;
      irq_num <= '0;
      vector  <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if ((cand != '0) && !stall) begin
            state   <= REQ;
            irq_num <= win[NW-1:0];
            vector  <= VEC_BASE + (32'(win) * VEC_STRIDE);
          end
        end
        REQ: begin
          if (irq_ack) state <= SERVICE;
        end
        SERVICE: begin
          if (irq_ret) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq_req    = (state == REQ);
  assign irq_active = (state == SERVICE);

endmodule

// File: tb/tb_sapra_irq_ctrl.sv
// tb/tb_sapra_irq_ctrl.sv - directed self-checking bench for sapra_irq_ctrl
module tb_sapra_irq_ctrl;

  logic        clk;
  logic        key;
  logic [2:0]  irq_in;
  logic [2:0]  irq_en;
  logic        stall;
  logic        irq_ack;
  logic        irq_ret;
  logic        irq_req;
  logic [1:0]  irq_num;
  logic [31:0] vector;
  logic        irq_active;
  logic [2:0]  pending;

  int n_cmp;
  int n_err;

  sapra_irq_ctrl #(.N_IRQ(3)) dut (
    .CLOCK_50   (clk),
    .KEY        (key),
    .irq_in     (irq_in),
    .irq_en     (irq_en),
    .stall      (stall),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .irq_req    (irq_req),
    .irq_num    (irq_num),
    .vector     (vector),
    .irq_active (irq_active),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [1:0] num, input logic [31:0] vec);
    check({tag, ".req"}, {31'd0, irq_req}, {31'd0, req});
    if (req) begin
      check({tag, ".num"}, {30'd0, irq_num}, {30'd0, num});
      check({tag, ".vec"}, vector, vec);
    end
  endtask

  task automatic ack_ret();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    key = 1'b0; irq_in = '0; irq_en = '0; stall = 1'b0; irq_ack = 1'b0; irq_ret = 1'b0;
    tick(); tick();
    check("rst.req", {31'd0, irq_req}, 32'd0);
    check("rst.num", {30'd0, irq_num}, 32'd0);
    check("rst.vec", vector, 32'h100);
    check("rst.act", {31'd0, irq_active}, 32'd0);
    check("rst.pend", {29'd0, pending}, 32'd0);
    key = 1'b1;
    tick();

    // single pulse on line 0
    irq_en = 3'b111; irq_in = 3'b001; tick();
    check("t1.pend", {29'd0, pending}, 32'd1);
    check_req("t1.pre", 1'b0, 2'd0, 32'h0);
    irq_in = 3'b000; tick();
    check_req("t1", 1'b1, 2'd0, 32'h100);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t1.ackpend", {29'd0, pending}, 32'd0);
    check("t1.act", {31'd0, irq_active}, 32'd1);
    check("t1.reqlow", {31'd0, irq_req}, 32'd0);
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    check("t1.ret", {31'd0, irq_active}, 32'd0);

    // simultaneous edges on lines 2 and 1
    irq_in = 3'b110; tick();
    check("t2.pend", {29'd0, pending}, 32'd6);
    irq_in = 3'b000; tick();
    check_req("t2.a", 1'b1, 2'd1, 32'h108);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t2.pend2", {29'd0, pending}, 32'd4);
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    check_req("t2.idle", 1'b0, 2'd0, 32'h0);
    tick();
    check_req("t2.b", 1'b1, 2'd2, 32'h110);
    ack_ret();

    // masked line becomes eligible when enabled
    irq_en = 3'b000; irq_in = 3'b010; tick();
    irq_in = 3'b000; tick();
    check("t3.pend", {29'd0, pending}, 32'd2);
    check_req("t3.masked", 1'b0, 2'd0, 32'h0);
    irq_en = 3'b010; tick();
    check_req("t3", 1'b1, 2'd1, 32'h108);
    ack_ret();

    // stall holds off the request, but not once committed
    irq_en = 3'b111; stall = 1'b1; irq_in = 3'b001; tick();
    irq_in = 3'b000; tick(); tick();
    check_req("t4.stall", 1'b0, 2'd0, 32'h0);
    stall = 1'b0; tick();
    check_req("t4.go", 1'b1, 2'd0, 32'h100);
    stall = 1'b1; irq_in = 3'b010; tick();
    irq_in = 3'b000;
    check_req("t4.held", 1'b1, 2'd0, 32'h100);
    check("t4.pend", {29'd0, pending}, 32'd3);
    irq_ack = 1'b1; irq_ret = 1'b1; tick(); irq_ack = 1'b0; irq_ret = 1'b0;
    check("t4.ackret", {31'd0, irq_active}, 32'd1);
    check("t4.pend2", {29'd0, pending}, 32'd2);
    stall = 1'b0;
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    tick();
    check_req("t4.next", 1'b1, 2'd1, 32'h108);
    ack_ret();

    // edge in ack cycle survives the clear; repeat edge in service merges
    irq_in = 3'b001; tick();
    irq_in = 3'b000; tick();
    check_req("t5.req", 1'b1, 2'd0, 32'h100);
    irq_in = 3'b001; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 3'b000;
    check("t5.setwins", {29'd0, pending}, 32'd1);
    check("t5.act", {31'd0, irq_active}, 32'd1);
    tick();
    irq_in = 3'b001; tick(); irq_in = 3'b000;
    check("t5.merge", {29'd0, pending}, 32'd1);
    check_req("t5.nonest", 1'b0, 2'd0, 32'h0);
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    check("t5.ret", {31'd0, irq_active}, 32'd0);
    tick();
    check_req("t5.again", 1'b1, 2'd0, 32'h100);

    // asynchronous reset in REQ
    irq_in = 3'b100; tick(); irq_in = 3'b000;
    #2 key = 1'b0; #1;
    check("t6.req", {31'd0, irq_req}, 32'd0);
    check("t6.vec", vector, 32'h100);
    check("t6.num", {30'd0, irq_num}, 32'd0);
    check("t6.pend", {29'd0, pending}, 32'd0);
    check("t6.act", {31'd0, irq_active}, 32'd0);
    tick();
    key = 1'b1; tick();

    // stray handshake pulses in IDLE
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t7.ack.act", {31'd0, irq_active}, 32'd0);
    check("t7.ack.req", {31'd0, irq_req}, 32'd0);
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    check("t7.ret.act", {31'd0, irq_active}, 32'd0);
    check("t7.ret.req", {31'd0, irq_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
